// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin arbiter and its grant controller.
package rr_pkg;

    localparam int RR_REQCNT  = 5;
    localparam int RR_MAX_REQ = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } rr_state_e;

    // Out-of-range numbers yield all-zero, so callers get range checking for free.
    function automatic logic [RR_MAX_REQ-1:0] num2onehot(input logic [31:0] num,
                                                         input int reqcnt);
        logic [RR_MAX_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            oh[i] = (i < reqcnt) && (num == 32'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_timeout_cnt.sv
// Idle-cycle counter for a held grant; flags the last cycle before forced release.
module rr_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_to
            assign tc_o = 1'b0;
        end else begin : g_to
            assign tc_o = (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/rr_grant_ctrl.sv
// Turns the arbiter's selected number into a registered, held one-hot grant
// released on last beat or idle timeout, with a dead cycle for mux turnaround.
module rr_grant_ctrl
    import rr_pkg::*;
#(
    parameter int REQCNT   = RR_REQCNT,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int TIMEOUT  = 16,
    parameter int TOWIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [REQCNT-1:0]   req_i,
    input  logic [REQWIDTH-1:0] arb_num_i,
    output logic                arb_val_o,
    input  logic                beat_val_i,
    input  logic                beat_last_i,
    output logic [REQCNT-1:0]   gnt_o,
    output logic [REQWIDTH-1:0] gnt_num_o,
    output logic                gnt_val_o,
    output logic                timeout_o
);

    rr_state_e             state_q;
    logic [REQCNT-1:0]     gnt_q;
    logic [REQWIDTH-1:0]   gnt_num_q;
    logic                  gnt_val_q;
    logic                  timeout_q;

    logic [REQCNT-1:0]     cand_oh_d;
    logic                  cand_val_d;
    logic                  to_tc;

    // Out-of-range selects produce a zero one-hot, so they never match a request.
    assign cand_oh_d  = REQCNT'(num2onehot(32'(arb_num_i), REQCNT));
    assign cand_val_d = |(req_i & cand_oh_d);

    // Gated by reset so the arbiter does not advance on a grant that won't be taken.
    assign arb_val_o  = (state_q == IDLE) && cand_val_d && !rst_i;

    rr_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CW      (TOWIDTH)
    ) u_to_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i ((state_q != GRANT) || beat_val_i),
        .inc_i ((state_q == GRANT) && !beat_val_i),
        .tc_o  (to_tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_num_q <= '0;
            gnt_val_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cand_val_d) begin
                        state_q   <= GRANT;
                        gnt_q     <= cand_oh_d;
                        gnt_num_q <= arb_num_i;
                        gnt_val_q <= 1'b1;
                    end
                end
                GRANT: begin
                    // A last beat takes priority over a coincident timeout.
                    if ((beat_val_i && beat_last_i) || (!beat_val_i && to_tc)) begin
                        state_q   <= RELEASE;
                        gnt_q     <= '0;
                        gnt_num_q <= '0;
                        gnt_val_q <= 1'b0;
                        timeout_q <= !beat_val_i;
                    end
                end
                RELEASE: state_q <= IDLE;
                default: begin
                    state_q   <= IDLE;
                    gnt_q     <= '0;
                    gnt_num_q <= '0;
                    gnt_val_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_num_o = gnt_num_q;
    assign gnt_val_o = gnt_val_q;
    assign timeout_o = timeout_q;

endmodule
